// File: rtl/demm_run_ctrl_if.sv
// Tile command channel between the DEMM run controller and the compute array.
// The controller owns valid and the tile indices; the array owns ready and the completion pulses.
interface demm_run_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_m_idx;
    logic [15:0] cmd_n_idx;
    logic [15:0] cmd_k_idx;
    logic        cmd_first_k;
    logic        cmd_last_k;
    logic        tile_done;

    modport master (
        output cmd_valid, cmd_m_idx, cmd_n_idx, cmd_k_idx, cmd_first_k, cmd_last_k,
        input  cmd_ready, tile_done
    );

    modport slave (
        input  cmd_valid, cmd_m_idx, cmd_n_idx, cmd_k_idx, cmd_first_k, cmd_last_k,
        output cmd_ready, tile_done
    );
endinterface

// File: rtl/demm_run_ctrl.sv
// DEMM run controller: walks the (m,n,k) tile loop, issues one command per tile,
// tracks outstanding tiles and counts run cycles for the host-visible status word.
module demm_run_ctrl #(
    parameter int unsigned TILE_M          = 16,
    parameter int unsigned TILE_N          = 16,
    parameter int unsigned TILE_K          = 64,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [31:0]           ctrl_reg,
    input  logic [31:0]           M_num,
    input  logic [31:0]           N_num,
    input  logic [31:0]           K_num,
    demm_run_ctrl_if.master       cmd,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [63:0]           status_wire
);

    localparam int unsigned LOG_M = $clog2(TILE_M);
    localparam int unsigned LOG_N = $clog2(TILE_N);
    localparam int unsigned LOG_K = $clog2(TILE_K);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic        start_q;
    logic        start_edge;
    logic        abort;
    logic        accept_start;
    logic        unused_ctrl;

    logic [32:0] m_cnt, n_cnt, k_cnt;
    logic        cnt_ovf, cnt_zero;

    logic [15:0] m_tiles, n_tiles, k_tiles;
    logic [15:0] m_idx, n_idx, k_idx;
    logic        m_last, n_last, k_last, all_last;
    logic [7:0]  outstanding;
    logic        in_issue;
    logic        hs;

    assign start_edge   = ctrl_reg[0] & ~start_q;
    assign abort        = ctrl_reg[1];
    assign unused_ctrl  = ^ctrl_reg[31:2];
    assign accept_start = start_edge & ~abort & ((state == S_IDLE) | (state == S_DONE));

    // Ceiling division done in 33 bits so an all-ones dimension cannot wrap to zero
    assign m_cnt = ({1'b0, M_num} + 33'(TILE_M - 1)) >> LOG_M;
    assign n_cnt = ({1'b0, N_num} + 33'(TILE_N - 1)) >> LOG_N;
    assign k_cnt = ({1'b0, K_num} + 33'(TILE_K - 1)) >> LOG_K;

    assign cnt_ovf  = (|m_cnt[32:16]) | (|n_cnt[32:16]) | (|k_cnt[32:16]);
    assign cnt_zero = (m_cnt == '0) | (n_cnt == '0) | (k_cnt == '0);

    assign m_last   = (m_idx == m_tiles - 16'd1);
    assign n_last   = (n_idx == n_tiles - 16'd1);
    assign k_last   = (k_idx == k_tiles - 16'd1);
    assign all_last = m_last & n_last & k_last;

    assign in_issue = (state == S_ISSUE);
    // Abort drops valid in the same cycle so no handshake can race the flush
    assign cmd.cmd_valid   = in_issue & ~abort & (outstanding < 8'(MAX_OUTSTANDING));
    assign hs              = cmd.cmd_valid & cmd.cmd_ready;
    assign cmd.cmd_m_idx   = m_idx;
    assign cmd.cmd_n_idx   = n_idx;
    assign cmd.cmd_k_idx   = k_idx;
    assign cmd.cmd_first_k = in_issue & (k_idx == '0);
    assign cmd.cmd_last_k  = in_issue & k_last;

    assign busy = (state == S_SETUP) | (state == S_ISSUE) | (state == S_DRAIN);
    assign done = (state == S_DONE);

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: if (start_edge) state_nxt = S_SETUP;
                S_SETUP:        state_nxt = (cnt_ovf | cnt_zero) ? S_DONE : S_ISSUE;
                S_ISSUE:        if (hs && all_last) state_nxt = S_DRAIN;
                S_DRAIN:        if (outstanding == '0) state_nxt = S_DONE;
                default:        state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            start_q     <= 1'b0;
            outstanding <= '0;
            error       <= 1'b0;
            status_wire <= '0;
            m_tiles     <= '0;
            n_tiles     <= '0;
            k_tiles     <= '0;
            m_idx       <= '0;
            n_idx       <= '0;
            k_idx       <= '0;
        end else begin
            start_q <= ctrl_reg[0];

            if (abort) begin
                outstanding <= '0;
            end else begin
                case ({hs, cmd.tile_done})
                    2'b10:   outstanding <= outstanding + 8'd1;
                    2'b01:   if (outstanding != '0) outstanding <= outstanding - 8'd1;
                    default: outstanding <= outstanding;
                endcase
            end

            if (accept_start) error <= 1'b0;
            if (state == S_SETUP && !abort && cnt_ovf) error <= 1'b1;
            if (cmd.tile_done && !hs && outstanding == '0) error <= 1'b1;

            if (accept_start) status_wire <= '0;
            else if (busy && status_wire != '1) status_wire <= status_wire + 64'd1;

            if (state == S_SETUP) begin
                m_tiles <= m_cnt[15:0];
                n_tiles <= n_cnt[15:0];
                k_tiles <= k_cnt[15:0];
                m_idx   <= '0;
                n_idx   <= '0;
                k_idx   <= '0;
            end else if (hs) begin
                // k is innermost; each wrap carries into the next outer index
                if (k_last) begin
                    k_idx <= '0;
                    if (n_last) begin
                        n_idx <= '0;
                        m_idx <= m_last ? '0 : m_idx + 16'd1;
                    end else begin
                        n_idx <= n_idx + 16'd1;
                    end
                end else begin
                    k_idx <= k_idx + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_demm_run_ctrl.sv
// Self-checking bench for demm_run_ctrl: expected tile commands are generated from the
// dimensions with nested loops and consumed by an independent handshake monitor.
module tb_demm_run_ctrl;

    localparam int TM      = 16;
    localparam int TN      = 16;
    localparam int TK      = 64;
    localparam int MAX_OUT = 2;

    logic        aclk;
    logic        areset;
    logic [31:0] ctrl_reg;
    logic [31:0] M_num, N_num, K_num;
    logic        busy, done, error;
    logic [63:0] status_wire;

    demm_run_ctrl_if bus ();

    demm_run_ctrl #(
        .TILE_M(TM),
        .TILE_N(TN),
        .TILE_K(TK),
        .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .aclk(aclk),
        .areset(areset),
        .ctrl_reg(ctrl_reg),
        .M_num(M_num),
        .N_num(N_num),
        .K_num(K_num),
        .cmd(bus),
        .busy(busy),
        .done(done),
        .error(error),
        .status_wire(status_wire)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    int unsigned n_checks = 0;
    int unsigned n_errs   = 0;
    int unsigned cyc      = 0;
    int unsigned t_start  = 0;

    logic [49:0]  exp_q[$];
    int unsigned  hs_cycle[$];
    int unsigned  done_ptr    = 0;
    bit           auto_done   = 0;
    bit           rand_ready  = 0;
    bit           ready_fixed = 1;
    bit           manual_pulse = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock step: inputs owned by the bench change on the falling edge
    task automatic tick();
        bit fire;
        @(negedge aclk);
        cyc++;
        fire = 0;
        if (auto_done && done_ptr < hs_cycle.size() && hs_cycle[done_ptr] + 3 <= cyc) begin
            fire = 1;
            done_ptr++;
        end
        bus.tile_done = fire | manual_pulse;
        manual_pulse  = 0;
        bus.cmd_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
    endtask

    task automatic start_run(input logic [31:0] m, input logic [31:0] n, input logic [31:0] k,
                             output bit exp_err, output bit short_run);
        longint unsigned mt, nt, kt;
        mt = (64'(m) + TM - 1) / TM;
        nt = (64'(n) + TN - 1) / TN;
        kt = (64'(k) + TK - 1) / TK;
        exp_err   = (mt > 65535) || (nt > 65535) || (kt > 65535);
        short_run = exp_err || mt == 0 || nt == 0 || kt == 0;
        if (!short_run) begin
            for (longint unsigned mi = 0; mi < mt; mi++)
                for (longint unsigned ni = 0; ni < nt; ni++)
                    for (longint unsigned ki = 0; ki < kt; ki++)
                        exp_q.push_back({16'(mi), 16'(ni), 16'(ki), ki == 0, ki == kt - 1});
        end
        M_num    = m;
        N_num    = n;
        K_num    = k;
        ctrl_reg = 32'h1;
        t_start  = cyc;
        tick();
        ctrl_reg = 32'h0;
    endtask

    task automatic wait_done(input bit exp_err, input bit short_run, input int budget);
        bit got;
        int unsigned d;
        got = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            n_checks++;
            n_errs++;
            $display("FAIL done_timeout: done=%0b after %0d cycles, required 1", done, budget);
        end
        d = cyc - t_start;
        check("done", done, 1);
        check("error", error, exp_err);
        check("busy_end", busy, 0);
        check("status", status_wire, 64'(d - 1));
        if (short_run) check("short_latency", d, 2);
        check("cmds_left", exp_q.size(), 0);
    endtask

    // Monitor: samples after the falling-edge drive, i.e. what the next rising edge sees
    initial begin : monitor
        int unsigned model_out;
        bit          prev_stall;
        logic [49:0] prev_cmd, cur;
        logic [49:0] expv;
        model_out  = 0;
        prev_stall = 0;
        prev_cmd   = '0;
        forever begin
            @(negedge aclk);
            #3;
            if (areset || ctrl_reg[1]) begin
                exp_q.delete();
                model_out  = 0;
                prev_stall = 0;
            end else begin
                cur = {bus.cmd_m_idx, bus.cmd_n_idx, bus.cmd_k_idx, bus.cmd_first_k, bus.cmd_last_k};
                if (bus.cmd_valid) begin
                    check("outstanding_cap", model_out < MAX_OUT, 1);
                    if (prev_stall) check("stall_stable", cur, prev_cmd);
                    if (bus.cmd_ready) begin
                        hs_cycle.push_back(cyc);
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            n_errs++;
                            $display("FAIL cmd_extra: got cmd %0h, required none", cur);
                        end else begin
                            expv = exp_q.pop_front();
                            check("cmd_fields", cur, expv);
                        end
                    end
                    prev_stall = !bus.cmd_ready;
                    prev_cmd   = cur;
                end else begin
                    prev_stall = 0;
                end
                if (bus.cmd_valid && bus.cmd_ready && !bus.tile_done) model_out++;
                else if (!(bus.cmd_valid && bus.cmd_ready) && bus.tile_done && model_out > 0) model_out--;
            end
        end
    end

    initial begin : stimulus
        bit ee, sr;
        int unsigned hs0;
        logic [63:0] st0;

        areset        = 1'b1;
        ctrl_reg      = '0;
        M_num         = '0;
        N_num         = '0;
        K_num         = '0;
        bus.cmd_ready = 1'b0;
        bus.tile_done = 1'b0;
        repeat (3) tick();
        check("rst_valid", bus.cmd_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_status", status_wire, 0);
        check("rst_idx", {bus.cmd_m_idx, bus.cmd_n_idx, bus.cmd_k_idx, bus.cmd_first_k, bus.cmd_last_k}, 0);
        areset = 1'b0;
        tick();

        // Directed: 2x2x2 tiles with completions returned three cycles after each handshake
        auto_done = 1;
        ready_fixed = 1;
        start_run(32, 32, 128, ee, sr);
        wait_done(ee, sr, 400);
        check("status_min", status_wire >= 9, 1);

        start_run(17, 16, 1, ee, sr);
        wait_done(ee, sr, 200);

        start_run(32, 0, 64, ee, sr);
        wait_done(ee, sr, 50);

        start_run(32'hFFFF_FFFF, 16, 64, ee, sr);
        wait_done(ee, sr, 50);
        start_run(16, 16, 64, ee, sr);
        wait_done(ee, sr, 100);

        // Randomized dimensions and backpressure
        rand_ready = 1;
        for (int r = 0; r < 8; r++) begin
            start_run($urandom_range(0, 80), $urandom_range(0, 80), $urandom_range(0, 200), ee, sr);
            wait_done(ee, sr, 3000);
            repeat ($urandom_range(0, 3)) tick();
        end
        rand_ready = 0;

        // Outstanding limit without completions
        auto_done   = 0;
        ready_fixed = 1;
        hs0 = hs_cycle.size();
        start_run(64, 16, 64, ee, sr);
        repeat (10) tick();
        check("cap_hs_count", hs_cycle.size() - hs0, 2);
        check("cap_valid_low", bus.cmd_valid, 0);
        manual_pulse = 1;
        repeat (6) tick();
        check("cap_one_more", hs_cycle.size() - hs0, 3);
        check("cap_valid_low2", bus.cmd_valid, 0);

        ready_fixed  = 0;
        manual_pulse = 1;
        repeat (6) tick();
        check("stall_valid", bus.cmd_valid, 1);
        check("stall_no_hs", hs_cycle.size() - hs0, 3);
        check("stall_idx", {bus.cmd_m_idx, bus.cmd_n_idx, bus.cmd_k_idx}, {16'd3, 16'd0, 16'd0});

        // Start edge while busy must not restart the run
        st0 = status_wire;
        ctrl_reg = 32'h1;
        tick();
        ctrl_reg = 32'h0;
        repeat (3) tick();
        check("busy_start_ignored", busy, 1);
        check("busy_status_runs", status_wire > st0, 1);
        check("busy_idx_kept", bus.cmd_m_idx, 3);

        // Abort together with a start edge: abort wins
        ctrl_reg = 32'h3;
        tick();
        ctrl_reg = 32'h0;
        check("abort_busy", busy, 0);
        check("abort_valid", bus.cmd_valid, 0);
        check("abort_done", done, 0);
        check("abort_no_error", error, 0);
        tick();
        ctrl_reg = 32'h3;
        tick();
        ctrl_reg = 32'h0;
        tick();
        check("abort_beats_start", busy, 0);

        // Completion with nothing outstanding
        manual_pulse = 1;
        repeat (2) tick();
        check("spurious_error", error, 1);
        check("spurious_idle", busy, 0);

        done_ptr    = hs_cycle.size();
        auto_done   = 1;
        ready_fixed = 1;
        start_run(16, 16, 64, ee, sr);
        wait_done(ee, sr, 100);

        // Reset in the middle of a run
        start_run(64, 64, 64, ee, sr);
        repeat (8) tick();
        auto_done = 0;
        areset = 1'b1;
        tick();
        areset = 1'b0;
        done_ptr = hs_cycle.size();
        tick();
        check("midrst_busy", busy, 0);
        check("midrst_status", status_wire, 0);
        check("midrst_valid", bus.cmd_valid, 0);
        check("midrst_error", error, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/demm_run_ctrl.md
Name: demm_run_ctrl

Overview:
- Downstream of the DEMM AXI-Lite config block.
- Consumes the control word and the M/N/K dimension registers, and sequences the matrix-multiply tile loop.
- Issues one command per (m,n,k) tile to the compute array over a valid/ready handshake, and tracks tile completions.
- Drives the 64-bit status word (run cycle count) that the config block exposes to the host.

Parameters:
TILE_M, 16, rows per tile; power of two, at most 2^15
TILE_N, 16, columns per tile; power of two, at most 2^15
TILE_K, 64, reduction depth per tile; power of two, at most 2^15
MAX_OUTSTANDING, 8, maximum issued-but-not-completed tiles; range 1..255

Ports:
aclk  in  1  clock; single clock domain
areset  in  1  reset; synchronous, active-high
ctrl_reg  in  32  bit0 = start (rising-edge triggered), bit1 = abort (level), others ignored
M_num  in  32  M dimension in elements
N_num  in  32  N dimension in elements
K_num  in  32  K dimension in elements
cmd_valid  out  1  tile command valid
cmd_ready  in  1  compute array accepts command
cmd_m_idx  out  16  tile row index
cmd_n_idx  out  16  tile column index
cmd_k_idx  out  16  tile reduction index
cmd_first_k  out  1  cmd_k_idx == 0
cmd_last_k  out  1  cmd_k_idx == k_tiles-1
tile_done  in  1  one-cycle pulse per completed tile
busy  out  1  high in SETUP/ISSUE/DRAIN
done  out  1  sticky; high in DONE
error  out  1  sticky until next accepted start
status_wire  out  64  run cycle counter

Behaviour:
- Reset: all outputs 0; state IDLE; outstanding = 0; start-edge register = 0.
- Start edge = ctrl_reg[0] is 1 this cycle and was 0 last cycle. It is accepted only in IDLE or DONE; ignored while busy.
- Abort (ctrl_reg[1]=1): any state -> IDLE next cycle. Clears cmd_valid, busy, done, outstanding. Not an error. cmd_valid may drop without a handshake; the compute array is flushed separately. Abort wins over a simultaneous start.
- States:
  - IDLE/DONE --accepted start--> SETUP. status_wire <= 0; error <= 0; done <= 0.
  - SETUP (1 cycle): latch m_tiles = ceil(M/TILE_M), computed in 33 bits as (M+TILE_M-1)>>log2(TILE_M). Likewise n_tiles and k_tiles. Reset all indices to 0.
    - Any count > 65535 -> error <= 1, go to DONE, issue no commands.
    - Any count == 0 -> DONE, no commands, error stays 0.
    - Otherwise -> ISSUE.
  - ISSUE:
    - cmd_valid = (outstanding < MAX_OUTSTANDING).
    - Index and flag outputs are stable while cmd_valid && !cmd_ready.
    - On handshake: k increments first; on k wrap, n increments; on n wrap, m increments.
    - Handshake on the last tile (m,n,k all at max) -> DRAIN.
  - DRAIN: cmd_valid = 0; wait until outstanding == 0 -> DONE.
  - DONE: done = 1; status_wire frozen.
- Outstanding counter (8 bits):
  - +1 on handshake, −1 on tile_done, unchanged when both occur in the same cycle.
  - tile_done while outstanding == 0 and no handshake in the same cycle -> error <= 1, counter stays 0, run continues.
- status_wire increments by 1 every cycle in SETUP, ISSUE, or DRAIN. It saturates at all-ones.
- Latency: start edge sampled at cycle t -> SETUP at t+1 -> first cmd_valid at t+2.
- Minimum zero-dimension run: status_wire = 1 and done at t+2.
- A new start from DONE re-runs with the current M/N/K values.
- Reset mid-run: behaves as abort, plus all registers return to their reset values.

Test Plan:
- M=32,N=32,K=128, cmd_ready=1, tile_done returned 3 cycles after each handshake -> 8 commands in order. (m,n,k) = (0,0,0),(0,0,1),(0,1,0)…(1,1,1). first_k/last_k alternate. done=1, error=0, status_wire = 1+8+drain cycles.
- M=17,N=16,K=1 -> m_tiles=2,n_tiles=1,k_tiles=1. Two commands with first_k=last_k=1.
- N=0 -> no cmd_valid ever. done=1 two cycles after the start edge. status_wire=1. error=0.
- M=32'hFFFF_FFFF (TILE_M=16) -> error=1, done=1, zero commands. A subsequent start with M=16 clears error.
- MAX_OUTSTANDING=2, no tile_done returned -> exactly 2 handshakes, then cmd_valid=0. Pulse tile_done -> exactly one more command. Hold cmd_ready=0 for 5 cycles -> indices stable.
- Abort asserted after 3 handshakes -> busy=0 next cycle, outstanding=0. Start re-asserted while busy -> ignored. tile_done with outstanding=0 -> error=1.
